// File: rtl/imm_extend_pkg.sv
// imm_extend_pkg: mode codes and buffer depth shared by the immediate extender (IMM_EXTEND_BRANCH_EN enables mode 3)
package imm_extend_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_SIGN = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ZERO = 2'd1;
  localparam logic [MODE_W-1:0] MODE_LUI = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 2'd3;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extension; mode 3 is BRANCH only when IMM_EXTEND_BRANCH_EN is defined
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   data_in,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  result,
  output logic              err
);
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_core: OUT_W must be >= IN_W + 2");
  end
  logic [OUT_W-1:0] sext, zext, lui, br;
  logic br_err;
  assign sext = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
  assign zext = {{(OUT_W-IN_W){1'b0}}, data_in};
  assign lui = zext << IN_W;
`ifdef IMM_EXTEND_BRANCH_EN
  assign br = sext << 2;
  assign br_err = 1'b0;
`else
  // Illegal mode still produces an entry so the stream stays in order
  assign br = '0;
  assign br_err = (mode == MODE_BRANCH);
`endif
  always_comb begin
    result = mode == MODE_SIGN ? sext : mode == MODE_ZERO ? zext : mode == MODE_LUI ? lui : br;
    err = br_err;
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate extender with a 2-entry elastic result buffer (IMM_EXTEND_BRANCH_EN enables mode 3)
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   data_in,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              err,
  output logic [1:0]        level
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  logic [OUT_W-1:0] res;
  logic res_err, push, pop;
  logic [OUT_W-1:0] mem_d [BUF_DEPTH];
  logic mem_e [BUF_DEPTH];
  logic [PTR_W-1:0] head, tail;
  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data_in(data_in),
    .mode(mode),
    .result(res),
    .err(res_err)
  );
  always_comb begin
    in_ready = level != 2'(BUF_DEPTH);
    out_valid = level != 2'd0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    data_out = out_valid ? mem_d[head] : '0;
    err = out_valid && mem_e[head];
  end
  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      level <= 2'd0;
    end else begin
      if (push) begin
        mem_d[tail] <= res;
        mem_e[tail] <= res_err;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      level <= level + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and random checks of imm_extend_pipe against a queue reference model
module tb_imm_extend_pipe;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] data_in;
  logic [1:0] mode, level;
  logic [31:0] data_out;
  int n_cmp = 0, n_bad = 0;
  logic [32:0] q[$];
  logic [31:0] popped[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err(err), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    int s;
    s = int'($signed(d));
    if (m == 2'd0) return {1'b0, 32'(s)};
    if (m == 2'd1) return {1'b0, 32'(d)};
    if (m == 2'd2) return {1'b0, 32'(d) * 32'd65536};
`ifdef IMM_EXTEND_BRANCH_EN
    return {1'b0, 32'(s * 4)};
`else
    return {1'b1, 32'd0};
`endif
  endfunction

  // Called just after a falling edge; checks outputs, then advances one clock
  task automatic cycle(input logic iv, input logic [15:0] d, input logic [1:0] m, input logic ordy, input logic r);
    logic do_push, do_pop;
    rst = r; in_valid = iv; data_in = d; mode = m; out_ready = ordy;
    #1;
    check("level", 64'(level), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() != 2));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("data_out", 64'(data_out), q.size() != 0 ? 64'(q[0][31:0]) : 64'd0);
    check("err", 64'(err), q.size() != 0 ? 64'(q[0][32]) : 64'd0);
    do_push = !r && iv && q.size() < 2;
    do_pop = !r && ordy && q.size() > 0;
    if (do_pop) popped.push_back(data_out);
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ref_ext(d, m));
    end
    @(negedge clk);
  endtask

  task automatic push_one(input string tag, input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp, input logic exp_err);
    cycle(1'b1, d, m, 1'b0, 1'b0);
    check({tag, "_data"}, 64'(data_out), 64'(exp));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    cycle(1'b0, 16'd0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0; mode = '0; out_ready = 1'b0;
    @(negedge clk);
    cycle(1'b0, 16'd0, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 16'h1111, 2'd0, 1'b1, 1'b1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    push_one("sign_ffff", 16'hFFFF, 2'd0, 32'hFFFFFFFF, 1'b0);
    push_one("sign_7fff", 16'h7FFF, 2'd0, 32'h00007FFF, 1'b0);
    push_one("zero_ffff", 16'hFFFF, 2'd1, 32'h0000FFFF, 1'b0);
    push_one("lui_1234", 16'h1234, 2'd2, 32'h12340000, 1'b0);
`ifdef IMM_EXTEND_BRANCH_EN
    push_one("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFFFFFC, 1'b0);
`else
    push_one("branch_ffff", 16'hFFFF, 2'd3, 32'h00000000, 1'b1);
`endif

    popped.delete();
    cycle(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 2'd0, 1'b0, 1'b0);
    check("bp_level_full", 64'(level), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle(1'b1, 16'h0003, 2'd0, 1'b0, 1'b0);
    check("bp_stalled", 64'(level), 64'd2);
    cycle(1'b1, 16'h0003, 2'd0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0003, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    check("bp_count", 64'(popped.size()), 64'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++) check("bp_order", 64'(popped[i]), 64'(i + 1));

    popped.delete();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 16'(100 + i), 2'd1, 1'b1, 1'b0);
      check("stream_level", 64'(level), 64'd1);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    check("stream_count", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) check("stream_order", 64'(popped[i]), 64'(100 + i));
    cycle(1'b0, 16'd0, 2'd0, 1'b1, 1'b0);

    cycle(1'b1, 16'h00AA, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 16'h00BB, 2'd0, 1'b0, 1'b0);
    check("mid_rst_full", 64'(level), 64'd2);
    cycle(1'b1, 16'h0055, 2'd0, 1'b1, 1'b1);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, 16'd0, 2'd0, 1'b1, 1'b0);
    check("mid_rst_no_push", 64'(level), 64'd0);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 49) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, handshaked immediate extender for the MIPS datapath. It takes an `IN_W`-bit immediate plus a mode code and produces an `OUT_W`-bit operand. Supported modes are sign-extend, zero-extend, upper-load shift and branch-offset. Results pass through a 2-entry elastic buffer, so the decode stage and the ALU operand mux can stall independently.

## Interface
Parameters:
- `IN_W`, default 16: immediate width.
- `OUT_W`, default 32: result width. Must satisfy `OUT_W >= IN_W + 2`; elaboration fails otherwise.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: immediate and mode are valid this cycle.
- `in_ready`, output, 1: buffer can accept an entry.
- `data_in`, input, `IN_W`: immediate.
- `mode`, input, 2: 0 = SIGN, 1 = ZERO, 2 = LUI, 3 = BRANCH.
- `out_valid`, output, 1: `data_out` holds a result.
- `out_ready`, input, 1: consumer takes the result.
- `data_out`, output, `OUT_W`: extended result.
- `err`, output, 1: flag for the head entry; set when the mode is disabled in this build.
- `level`, output, 2: buffer occupancy, 0 to 2.

## Operation
- Push: `in_valid && in_ready` at a rising edge. Pop: `out_valid && out_ready` at a rising edge.
- The result is computed combinationally at push and stored together with its `err` bit. The buffer stores results, not raw operands.
- SIGN: replicate `data_in[IN_W-1]` into the upper `OUT_W-IN_W` bits.
- ZERO: upper bits are 0.
- LUI: `data_in << IN_W`, truncated to `OUT_W`; low `IN_W` bits are 0.
- BRANCH: sign-extend, then shift left by 2; the 2 LSBs are 0. Bits shifted past the MSB are discarded.
- Buffer behaviour:
  - FIFO order is strict.
  - `in_ready = (level != 2)` and `out_valid = (level != 0)`. Both are registered state only; neither depends combinationally on `in_valid` or `out_ready`.
  - Push and pop in the same cycle: `level` is unchanged, and the head advances while the new entry enters at the tail.
  - When `level == 2`, no push is possible because `in_ready` is 0. A pop in that cycle drops `level` to 1, and `in_ready` rises on the next cycle.
  - When `level == 0`: `data_out` and `err` are held at 0 and `out_valid` is 0.
- Reset (`rst` high at an edge, including mid-transfer):
  - `level` goes to 0 and all stored entries are discarded.
  - Next cycle: `out_valid = 0`, `data_out = 0`, `err = 0`, `in_ready = 1`.
  - A push or pop presented in the reset cycle is ignored.

## Timing
- Latency is 1 cycle. An entry pushed at edge N is visible on `data_out` with `out_valid = 1` after edge N, provided it is the head.
- Throughput is 1 result per cycle when `out_ready` is held high.
- `data_out` changes only at an edge where a pop or a push-into-empty occurs; otherwise it is stable while `out_valid` is high.
- After reset, the first push is accepted on the first edge with `rst` low.

## Configuration
- `IMM_EXTEND_BRANCH_EN` defined: mode 3 behaves as BRANCH as described above, and `err` is always 0.
- `IMM_EXTEND_BRANCH_EN` undefined: mode 3 is illegal.
  - The entry is still accepted and stored with result 0 and `err = 1`.
  - `err` is presented with that entry at the head; it is not sticky.

## Structure
- Package `imm_extend_pkg` holds:
  - the mode localparams `MODE_SIGN`, `MODE_ZERO`, `MODE_LUI`, `MODE_BRANCH`;
  - the mode width (2);
  - the depth constant `BUF_DEPTH = 2`.
- Sub-module `imm_extend_core`: purely combinational mapping of (`data_in`, `mode`) to (result, `err`), parametrised by `IN_W` and `OUT_W`. It contains the only `IMM_EXTEND_BRANCH_EN` conditional.
- The top level holds the 2-entry storage, head/tail pointers, level counter and handshake logic.

## Test plan
All scenarios use `IN_W = 16`, `OUT_W = 32`.
- Extension values:
  - SIGN `0xFFFF` gives `0xFFFFFFFF`.
  - SIGN `0x7FFF` gives `0x00007FFF`.
  - ZERO `0xFFFF` gives `0x0000FFFF`.
  - LUI `0x1234` gives `0x12340000`.
  - In each case `out_valid` is high 1 cycle after the push.
- BRANCH `0xFFFF`:
  - with the macro: `0xFFFFFFFC`, `err = 0`;
  - without the macro: `0x00000000`, `err = 1`.
- Backpressure: hold `out_ready = 0` and push `A = 0x0001`, `B = 0x0002`, `C = 0x0003` (SIGN).
  - `level` reaches 2 and `in_ready` goes to 0, so C stalls.
  - Raise `out_ready`: outputs appear in the order `0x00000001`, `0x00000002`, `0x00000003`, with no loss or duplication.
- Streaming: `in_valid` and `out_ready` held high for 8 cycles.
  - 8 results at 1 per cycle.
  - `level` stays at 1.
  - Same-cycle push and pop never stalls.
- Reset mid-operation: assert `rst` for 1 cycle with `level = 2`.
  - Next cycle: `level = 0`, `out_valid = 0`, `data_out = 0`, `in_ready = 1`.
  - The push offered during the reset cycle is not retained.
